// File: rtl/tx_char_scheduler_if.sv
// Character handshake between the TX scheduler and the TX encoder.
// The scheduler drives the master side and the encoder answers on the slave side.
interface tx_char_scheduler_if #(
  parameter int DATA_W = 9
);
  logic              char_valid;
  logic [1:0]        char_type;
  logic [DATA_W-1:0] char_data;
  logic              encoder_ready;

  modport master (
    output char_valid,
    output char_type,
    output char_data,
    input  encoder_ready
  );

  modport slave (
    input  char_valid,
    input  char_type,
    input  char_data,
    output encoder_ready
  );
endinterface

// File: rtl/tx_char_scheduler.sv
// Transmit-side arbiter: chooses time-code, then FCT, then N-char for the TX encoder.
// Each N-char spends one credit and is followed by a short guard before the next one.
module tx_char_scheduler #(
  parameter int DATA_W       = 9,
  parameter int CREDIT_W     = 6,
  parameter int GUARD_CYCLES = 3
) (
  input  logic                pclk_tx,
  input  logic                reset_tx,
  input  logic                enable_tx,
  input  logic [CREDIT_W-1:0] fct_counter_p,
  input  logic                fifo_empty,
  input  logic [DATA_W-1:0]   fifo_data,
  output logic                fifo_rd,
  input  logic                fct_request,
  output logic                fct_ack,
  input  logic                tick_tx,
  input  logic [7:0]          time_in,
  tx_char_scheduler_if.master enc,
  output logic                char_sent
);

  localparam int GW = $clog2(GUARD_CYCLES + 2);

  localparam logic [1:0] TYPE_FCT   = 2'b01;
  localparam logic [1:0] TYPE_NCHAR = 2'b10;
  localparam logic [1:0] TYPE_TIME  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [1:0]        type_q;
  logic [DATA_W-1:0] data_q;
  logic              tick_pending;
  logic [7:0]        time_reg;
  logic [GW-1:0]     guard_cnt;

  logic              run;
  logic              accept;
  logic              tick_live;
  logic [7:0]        time_live;
  logic              nchar_ok;

  // A tick arriving this very cycle already counts as pending, carrying the newest time value.
  assign run       = enable_tx && !reset_tx;
  assign accept    = (state == SEND) && enc.encoder_ready;
  assign tick_live = tick_pending || tick_tx;
  assign time_live = tick_tx ? time_in : time_reg;
  assign nchar_ok  = !fifo_empty && (fct_counter_p != '0) && (guard_cnt == '0);

  assign enc.char_valid = (state == SEND);
  assign enc.char_type  = type_q;
  assign enc.char_data  = data_q;
  assign fct_ack        = run && accept && (type_q == TYPE_FCT);

  always_comb begin
    next_state = state;
    fifo_rd    = 1'b0;
    case (state)
      IDLE: begin
        if (tick_live || fct_request) begin
          next_state = SEND;
        end else if (nchar_ok) begin
          next_state = LOAD;
          fifo_rd    = run;
        end
      end
      LOAD:    next_state = SEND;
      SEND:    if (accept) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge pclk_tx) begin
    if (!run) begin
      state        <= IDLE;
      type_q       <= 2'b00;
      data_q       <= '0;
      tick_pending <= 1'b0;
      time_reg     <= 8'h00;
      guard_cnt    <= '0;
      char_sent    <= 1'b0;
    end else begin
      state     <= next_state;
      char_sent <= accept && (type_q == TYPE_NCHAR);

      if (accept && (type_q == TYPE_NCHAR)) begin
        guard_cnt <= GW'(GUARD_CYCLES);
      end else if (guard_cnt != '0) begin
        guard_cnt <= guard_cnt - GW'(1);
      end

      // A fresh tick in the accept cycle of a time-code re-arms rather than being lost.
      if (tick_tx) begin
        tick_pending <= 1'b1;
        time_reg     <= time_in;
      end else if (accept && (type_q == TYPE_TIME)) begin
        tick_pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (tick_live) begin
            type_q <= TYPE_TIME;
            data_q <= DATA_W'(time_live);
          end else if (fct_request) begin
            type_q <= TYPE_FCT;
            data_q <= '0;
          end
        end
        LOAD: begin
          type_q <= TYPE_NCHAR;
          data_q <= fifo_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_char_scheduler.sv
// Directed bench for tx_char_scheduler: small FIFO model, acceptance log and
// hand-computed expectations checked with immediate assertions.
module tb_tx_char_scheduler;

  localparam int DATA_W   = 9;
  localparam int CREDIT_W = 6;

  logic                pclk_tx = 1'b0;
  logic                reset_tx;
  logic                enable_tx;
  logic [CREDIT_W-1:0] fct_counter_p;
  logic                fifo_empty;
  logic [DATA_W-1:0]   fifo_data;
  logic                fifo_rd;
  logic                fct_request;
  logic                fct_ack;
  logic                tick_tx;
  logic [7:0]          time_in;
  logic                char_sent;

  tx_char_scheduler_if #(.DATA_W(DATA_W)) enc_bus ();

  tx_char_scheduler #(
    .DATA_W      (DATA_W),
    .CREDIT_W    (CREDIT_W),
    .GUARD_CYCLES(3)
  ) dut (
    .pclk_tx      (pclk_tx),
    .reset_tx     (reset_tx),
    .enable_tx    (enable_tx),
    .fct_counter_p(fct_counter_p),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_rd      (fifo_rd),
    .fct_request  (fct_request),
    .fct_ack      (fct_ack),
    .tick_tx      (tick_tx),
    .time_in      (time_in),
    .enc          (enc_bus.master),
    .char_sent    (char_sent)
  );

  always #5 pclk_tx = ~pclk_tx;

  // FIFO model: read data appears the cycle after the pop strobe.
  logic [DATA_W-1:0] fifo_mem [16];
  int fifo_head = 0;
  int fifo_tail = 0;

  assign fifo_empty = (fifo_head == fifo_tail);

  initial fifo_data = '0;

  always @(posedge pclk_tx) begin
    if (fifo_rd && (fifo_head != fifo_tail)) begin
      fifo_data <= fifo_mem[fifo_head % 16];
      fifo_head <= fifo_head + 1;
    end
  end

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int pop_count = 0;
  int sent_count = 0;
  int ack_count = 0;
  int sent_cycle [$];
  logic [10:0] log_q [$];

  // Sampled mid-cycle so registered and combinational outputs have settled.
  always @(negedge pclk_tx) begin
    cycle++;
    if (fifo_rd) pop_count++;
    if (char_sent) begin
      sent_count++;
      sent_cycle.push_back(cycle);
    end
    if (fct_ack) ack_count++;
    if (!reset_tx && enable_tx && enc_bus.char_valid && enc_bus.encoder_ready)
      log_q.push_back({enc_bus.char_type, enc_bus.char_data});
  end

  function automatic logic [31:0] expChar(input logic [1:0] t, input logic [8:0] d);
    return {21'd0, t, d};
  endfunction

  function automatic logic [31:0] logAt(input int i);
    if (i < log_q.size()) return {21'd0, log_q[i]};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] sentGap(input int i);
    if (i + 1 < sent_cycle.size()) return 32'(sent_cycle[i+1] - sent_cycle[i]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic pushFifo(input logic [DATA_W-1:0] d);
    fifo_mem[fifo_tail % 16] = d;
    fifo_tail = fifo_tail + 1;
  endtask

  // Advances n cycles; the FCT requester drops its level at the edge after fct_ack.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      logic ack_seen;
      @(negedge pclk_tx);
      ack_seen = fct_ack;
      @(posedge pclk_tx);
      #1;
      if (ack_seen) fct_request = 1'b0;
    end
  endtask

  task automatic waitValid(input string tag, input int budget);
    int n;
    n = 0;
    while (!enc_bus.char_valid && n < budget) begin
      applyStimulus(1);
      n++;
    end
    checkOutput(tag, 32'(enc_bus.char_valid), 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pops0;
    int sent0;
    int acks0;

    reset_tx              = 1'b1;
    enable_tx             = 1'b1;
    fct_counter_p         = 6'd8;
    fct_request           = 1'b0;
    tick_tx               = 1'b0;
    time_in               = 8'h00;
    enc_bus.encoder_ready = 1'b1;
    pushFifo(9'h011);
    pushFifo(9'h1A5);
    pushFifo(9'h0C3);

    // Reset holds everything quiet even with data and credit available.
    applyStimulus(3);
    checkOutput("rst_valid", 32'(enc_bus.char_valid), 32'd0);
    checkOutput("rst_type", 32'(enc_bus.char_type), 32'd0);
    checkOutput("rst_data", 32'(enc_bus.char_data), 32'd0);
    checkOutput("rst_sent", 32'(char_sent), 32'd0);
    checkOutput("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    checkOutput("rst_pops", pop_count, 32'd0);

    // T1: three N-chars in order, char_sent pulses 6 cycles apart (3 guard + 2 latency + send).
    log_q.delete();
    sent_cycle.delete();
    reset_tx = 1'b0;
    applyStimulus(40);
    checkOutput("t1_count", log_q.size(), 32'd3);
    checkOutput("t1_char0", logAt(0), expChar(2'b10, 9'h011));
    checkOutput("t1_char1", logAt(1), expChar(2'b10, 9'h1A5));
    checkOutput("t1_char2", logAt(2), expChar(2'b10, 9'h0C3));
    checkOutput("t1_sent", sent_count, 32'd3);
    checkOutput("t1_pops", pop_count, 32'd3);
    checkOutput("t1_gap01", sentGap(0), 32'd6);
    checkOutput("t1_gap12", sentGap(1), 32'd6);

    // T2: no credit blocks the pop; credit arrival pops, valid two cycles later.
    fct_counter_p         = 6'd0;
    enc_bus.encoder_ready = 1'b0;
    pushFifo(9'h055);
    pops0 = pop_count;
    applyStimulus(5);
    checkOutput("t2_no_rd", 32'(fifo_rd), 32'd0);
    checkOutput("t2_no_pops", pop_count, pops0);
    checkOutput("t2_no_valid", 32'(enc_bus.char_valid), 32'd0);
    fct_counter_p = 6'd8;
    #1;
    checkOutput("t2_rd", 32'(fifo_rd), 32'd1);
    applyStimulus(1);
    checkOutput("t2_load_valid", 32'(enc_bus.char_valid), 32'd0);
    checkOutput("t2_load_rd", 32'(fifo_rd), 32'd0);
    applyStimulus(1);
    checkOutput("t2_valid", 32'(enc_bus.char_valid), 32'd1);
    checkOutput("t2_type", 32'(enc_bus.char_type), 32'd2);
    checkOutput("t2_data", 32'(enc_bus.char_data), 32'h055);

    // T4: stalled encoder sees a stable character, then exactly one char_sent.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1);
      checkOutput("t4_valid", 32'(enc_bus.char_valid), 32'd1);
      checkOutput("t4_type", 32'(enc_bus.char_type), 32'd2);
      checkOutput("t4_data", 32'(enc_bus.char_data), 32'h055);
      checkOutput("t4_no_sent", 32'(char_sent), 32'd0);
    end
    sent0 = sent_count;
    enc_bus.encoder_ready = 1'b1;
    applyStimulus(1);
    checkOutput("t4_sent_pulse", 32'(char_sent), 32'd1);
    checkOutput("t4_idle_valid", 32'(enc_bus.char_valid), 32'd0);
    applyStimulus(1);
    checkOutput("t4_sent_drop", 32'(char_sent), 32'd0);
    applyStimulus(5);
    checkOutput("t4_sent_once", sent_count, sent0 + 1);

    // T3: simultaneous tick, FCT request and N-char resolve in priority order.
    log_q.delete();
    acks0       = ack_count;
    tick_tx     = 1'b1;
    time_in     = 8'h2A;
    fct_request = 1'b1;
    pushFifo(9'h100);
    applyStimulus(1);
    tick_tx = 1'b0;
    applyStimulus(14);
    checkOutput("t3_count", log_q.size(), 32'd3);
    checkOutput("t3_first_time", logAt(0), expChar(2'b11, 9'h02A));
    checkOutput("t3_second_fct", logAt(1), expChar(2'b01, 9'h000));
    checkOutput("t3_third_nchar", logAt(2), expChar(2'b10, 9'h100));
    checkOutput("t3_acks", ack_count, acks0 + 1);

    // T5: reset in SEND abandons the N-char with no char_sent and no re-pop.
    log_q.delete();
    enc_bus.encoder_ready = 1'b0;
    pops0 = pop_count;
    sent0 = sent_count;
    pushFifo(9'h077);
    waitValid("t5_reach_send", 20);
    checkOutput("t5_one_pop", pop_count, pops0 + 1);
    reset_tx = 1'b1;
    applyStimulus(1);
    reset_tx = 1'b0;
    checkOutput("t5_valid_drop", 32'(enc_bus.char_valid), 32'd0);
    enc_bus.encoder_ready = 1'b1;
    applyStimulus(8);
    checkOutput("t5_no_sent", sent_count, sent0);
    checkOutput("t5_no_repop", pop_count, pops0 + 1);
    checkOutput("t5_no_accept", log_q.size(), 32'd0);

    // Link leaving Run behaves like reset; returning to Run resumes normally.
    pushFifo(9'h0AB);
    enable_tx = 1'b0;
    #1;
    checkOutput("en_low_no_rd", 32'(fifo_rd), 32'd0);
    applyStimulus(2);
    checkOutput("en_low_valid", 32'(enc_bus.char_valid), 32'd0);
    enable_tx = 1'b1;
    #1;
    checkOutput("en_high_rd", 32'(fifo_rd), 32'd1);
    applyStimulus(6);
    checkOutput("en_char", logAt(0), expChar(2'b10, 9'h0AB));

    // T6: two ticks during an FCT stall collapse into one time-code with the later value.
    log_q.delete();
    enc_bus.encoder_ready = 1'b0;
    fct_request = 1'b1;
    applyStimulus(1);
    checkOutput("t6_fct_valid", 32'(enc_bus.char_valid), 32'd1);
    checkOutput("t6_fct_type", 32'(enc_bus.char_type), 32'd1);
    checkOutput("t6_no_ack_stalled", 32'(fct_ack), 32'd0);
    applyStimulus(1);
    tick_tx = 1'b1;
    time_in = 8'h05;
    applyStimulus(1);
    tick_tx = 1'b0;
    applyStimulus(1);
    tick_tx = 1'b1;
    time_in = 8'h06;
    applyStimulus(1);
    tick_tx = 1'b0;
    applyStimulus(1);
    enc_bus.encoder_ready = 1'b1;
    applyStimulus(10);
    checkOutput("t6_count", log_q.size(), 32'd2);
    checkOutput("t6_fct", logAt(0), expChar(2'b01, 9'h000));
    checkOutput("t6_time", logAt(1), expChar(2'b11, 9'h006));

    // T7: a tick in the accept cycle of a time-code re-arms a second time-code.
    log_q.delete();
    tick_tx = 1'b1;
    time_in = 8'h10;
    applyStimulus(1);
    time_in = 8'h11;
    applyStimulus(1);
    tick_tx = 1'b0;
    applyStimulus(6);
    checkOutput("t7_count", log_q.size(), 32'd2);
    checkOutput("t7_first", logAt(0), expChar(2'b11, 9'h010));
    checkOutput("t7_rearm", logAt(1), expChar(2'b11, 9'h011));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
